// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types and limits for the dual-port RAM bank.
package dpram_pkg;
   typedef enum logic {ST_CLEAR, ST_RUN} state_e;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;
   localparam int CNT_W = 16;
endpackage

// File: rtl/dpram_port_pipe.sv
// dpram_port_pipe: RD_LAT-deep valid/data/collide response pipeline for one RAM port.
module dpram_port_pipe import dpram_pkg::*; #(
   parameter int DW = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          in_collide,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic          out_collide,
   output logic [DW-1:0] out_data
);
   localparam int LAT = RD_LAT < RD_LAT_MIN ? RD_LAT_MIN : (RD_LAT > RD_LAT_MAX ? RD_LAT_MAX : RD_LAT);
   logic [LAT-1:0] v_q, v_d, c_q, c_d;
   logic [DW-1:0] d_q [LAT];
   logic [DW-1:0] d_d [LAT];
   always_comb begin
      v_d = LAT'({v_q, in_valid});
      c_d = LAT'({c_q, in_collide});
      d_d[0] = in_data;
      for (int i = 1; i < LAT; i++) d_d[i] = d_q[i-1];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         c_q <= '0;
         for (int i = 0; i < LAT; i++) d_q[i] <= '0;
      end else begin
         v_q <= v_d;
         c_q <= c_d;
         d_q <= d_d;
      end
   end
   assign out_valid = v_q[LAT-1];
   assign out_collide = c_q[LAT-1];
   assign out_data = d_q[LAT-1];
endmodule

// File: rtl/dpram_bank.sv
// dpram_bank: true dual-port word RAM with handshake, selectable read latency and clear sweep.
// Define DPRAM_COLLIDE_CNT_EN to add the saturating collide_cnt output.
module dpram_bank import dpram_pkg::*; #(
   parameter int DW = 16,
   parameter int AW = 10,
   parameter int RD_LAT = 1,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_req,
   output logic             ready,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [AW-1:0]    a_addr,
   input  logic [DW-1:0]    a_wdata,
   output logic             a_rvalid,
   output logic [DW-1:0]    a_rdata,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [AW-1:0]    b_addr,
   input  logic [DW-1:0]    b_wdata,
   output logic             b_rvalid,
   output logic [DW-1:0]    b_rdata,
`ifdef DPRAM_COLLIDE_CNT_EN
   output logic [CNT_W-1:0] collide_cnt,
`endif
   output logic             b_collide
);
   localparam int DEPTH = 1 << AW;
   state_e state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic a_acc, b_acc, collide;
   logic [DW-1:0] a_resp, b_resp;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         ptr_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
      end
   end
   always_comb begin
      state_d = state_q == ST_CLEAR ? (ptr_q == '1 ? ST_RUN : ST_CLEAR) : (clear_req ? ST_CLEAR : ST_RUN);
      ptr_d = state_q == ST_CLEAR ? ptr_q + 1'b1 : '0;
   end
   always_comb ready = state_q == ST_RUN;
   // A wins a same-address write collision; reads see pre-edge contents (read-first)
   always_comb begin
      a_acc = a_req & ready;
      b_acc = b_req & ready;
      collide = a_acc & a_we & b_acc & b_we & (a_addr == b_addr);
      a_resp = a_we ? a_wdata : mem_q[a_addr];
      b_resp = b_we ? b_wdata : mem_q[b_addr];
   end
   always_ff @(posedge clk) begin
      if (!ready) mem_q[ptr_q] <= INIT_VAL;
      else if (a_acc & a_we) mem_q[a_addr] <= a_wdata;
      if (b_acc & b_we & !collide) mem_q[b_addr] <= b_wdata;
   end
   dpram_port_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_acc), .in_collide(1'b0), .in_data(a_resp),
      .out_valid(a_rvalid), .out_collide(), .out_data(a_rdata)
   );
   dpram_port_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_acc), .in_collide(collide), .in_data(b_resp),
      .out_valid(b_rvalid), .out_collide(b_collide), .out_data(b_rdata)
   );
`ifdef DPRAM_COLLIDE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = (ready & clear_req) ? '0 : (b_collide && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign collide_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_dpram_bank.sv
// tb_dpram_bank: scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances with shared directed stimulus.
module tb_dpram_bank;
   localparam logic [15:0] INIT = 16'hA5A5;
   typedef struct packed {logic [15:0] d; logic c; int due;} exp_t;
   logic clk = 1'b0;
   logic rst_n;
   logic clear_req = 1'b0;
   logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [3:0] a_addr = '0, b_addr = '0;
   logic [15:0] a_wdata = '0, b_wdata = '0;
   logic rdy1, av1, bv1, bc1, rdy2, av2, bv2, bc2;
   logic [15:0] ad1, bd1, ad2, bd2;
   logic [15:0] cnt1, cnt2;
   exp_t qa1[$], qb1[$], qa2[$], qb2[$];
   logic [15:0] mem [16];
   int total = 0, bad = 0, cyc = 0, sweep_left = 16, ccnt1 = 0, ccnt2 = 0;
   always #5 clk = ~clk;
   dpram_bank #(.DW(16), .AW(4), .RD_LAT(1), .INIT_VAL(INIT)) u1 (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(rdy1),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(av1), .a_rdata(ad1),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(bv1), .b_rdata(bd1),
`ifdef DPRAM_COLLIDE_CNT_EN
      .collide_cnt(cnt1),
`endif
      .b_collide(bc1)
   );
   dpram_bank #(.DW(16), .AW(4), .RD_LAT(2), .INIT_VAL(INIT)) u2 (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(rdy2),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(av2), .a_rdata(ad2),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(bv2), .b_rdata(bd2),
`ifdef DPRAM_COLLIDE_CNT_EN
      .collide_cnt(cnt2),
`endif
      .b_collide(bc2)
   );
`ifndef DPRAM_COLLIDE_CNT_EN
   assign cnt1 = '0;
   assign cnt2 = '0;
`endif
   task automatic chk(input string nm, input int p, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s port%0d got=%0h want=%0h t=%0t", nm, p, act, exp, $time);
      end
   endtask
   function automatic int qsize(input int p);
      case (p)
         0: return qa1.size();
         1: return qb1.size();
         2: return qa2.size();
         default: return qb2.size();
      endcase
   endfunction
   function automatic exp_t qfront(input int p);
      case (p)
         0: return qa1[0];
         1: return qb1[0];
         2: return qa2[0];
         default: return qb2[0];
      endcase
   endfunction
   function automatic exp_t qpop(input int p);
      case (p)
         0: return qa1.pop_front();
         1: return qb1.pop_front();
         2: return qa2.pop_front();
         default: return qb2.pop_front();
      endcase
   endfunction
   task automatic qpush(input int p, input logic [15:0] d, input logic c, input int due);
      exp_t e;
      e = '{d: d, c: c, due: due};
      case (p)
         0: qa1.push_back(e);
         1: qb1.push_back(e);
         2: qa2.push_back(e);
         default: qb2.push_back(e);
      endcase
   endtask
   // Port index: 0=u1.A 1=u1.B 2=u2.A 3=u2.B
   task automatic mon(input int p, input logic v, input logic [15:0] d, input logic c);
      exp_t e;
      if (v) begin
         if (qsize(p) == 0) chk("unexpected_rvalid", p, 64'(v), 64'd0);
         else begin
            e = qpop(p);
            chk("rdata", p, 64'(d), 64'(e.d));
            chk("collide", p, 64'(c), 64'(e.c));
            chk("latency", p, 64'(cyc), 64'(e.due));
            if (e.c && p == 1) ccnt1++;
            if (e.c && p == 3) ccnt2++;
         end
      end else begin
         chk("collide_idle", p, 64'(c), 64'd0);
         if (qsize(p) != 0 && qfront(p).due <= cyc) begin
            e = qpop(p);
            chk("missing_rvalid", p, 64'(v), 64'd1);
         end
      end
   endtask
   always @(negedge clk or negedge rst_n) begin
      logic rdy, col;
      logic [15:0] ra, rb;
      if (!rst_n) begin
         qa1.delete(); qb1.delete(); qa2.delete(); qb2.delete();
         sweep_left = 16;
         ccnt1 = 0;
         ccnt2 = 0;
         for (int i = 0; i < 16; i++) mem[i] = INIT;
      end else begin
         cyc++;
         mon(0, av1, ad1, 1'b0);
         mon(1, bv1, bd1, bc1);
         mon(2, av2, ad2, 1'b0);
         mon(3, bv2, bd2, bc2);
         rdy = sweep_left == 0;
         chk("ready", 0, 64'(rdy1), 64'(rdy));
         chk("ready", 2, 64'(rdy2), 64'(rdy));
         if (rdy) begin
            ra = mem[a_addr];
            rb = mem[b_addr];
            col = a_req & a_we & b_req & b_we & (a_addr == b_addr);
            if (a_req) begin
               qpush(0, a_we ? a_wdata : ra, 1'b0, cyc + 1);
               qpush(2, a_we ? a_wdata : ra, 1'b0, cyc + 2);
            end
            if (b_req) begin
               qpush(1, b_we ? b_wdata : rb, col, cyc + 1);
               qpush(3, b_we ? b_wdata : rb, col, cyc + 2);
            end
            if (a_req & a_we) mem[a_addr] = a_wdata;
            if (b_req & b_we & !col) mem[b_addr] = b_wdata;
            if (clear_req) begin
               sweep_left = 16;
               ccnt1 = 0;
               ccnt2 = 0;
               for (int i = 0; i < 16; i++) mem[i] = INIT;
            end
         end else sweep_left--;
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic req(input logic ar, input logic aw, input logic [3:0] aa, input logic [15:0] ad,
                      input logic br, input logic bw, input logic [3:0] ba, input logic [15:0] bd);
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
      step();
   endtask
   task automatic idle(input int n);
      a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0; clear_req = 1'b0;
      repeat (n) step();
   endtask
   task automatic check_zero(input string nm);
      chk({nm, "_ready"}, 0, 64'(rdy1), 64'd0);
      chk({nm, "_arvalid"}, 0, 64'(av1), 64'd0);
      chk({nm, "_ardata"}, 0, 64'(ad1), 64'd0);
      chk({nm, "_brvalid"}, 1, 64'(bv1), 64'd0);
      chk({nm, "_brdata"}, 1, 64'(bd1), 64'd0);
      chk({nm, "_bcollide"}, 1, 64'(bc1), 64'd0);
      chk({nm, "_ready"}, 2, 64'(rdy2), 64'd0);
      chk({nm, "_arvalid"}, 2, 64'(av2), 64'd0);
      chk({nm, "_ardata"}, 2, 64'(ad2), 64'd0);
      chk({nm, "_brvalid"}, 3, 64'(bv2), 64'd0);
      chk({nm, "_brdata"}, 3, 64'(bd2), 64'd0);
      chk({nm, "_bcollide"}, 3, 64'(bc2), 64'd0);
   endtask
   task automatic check_cnt(input string nm);
`ifdef DPRAM_COLLIDE_CNT_EN
      chk(nm, 1, 64'(cnt1), 64'(ccnt1));
      chk(nm, 3, 64'(cnt2), 64'(ccnt2));
`else
      chk(nm, 1, 64'(cnt1 | cnt2), 64'd0);
`endif
   endtask
   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      // Requests during the power-on sweep must be ignored
      for (int i = 0; i < 16; i++) req(1, 0, 4'h2, 16'h0, 1, 1, 4'h9, 16'hDEAD);
      for (int i = 0; i < 16; i++) req(1, 0, 4'(i), 16'h0, 1, 0, 4'(15 - i), 16'h0);
      req(1, 1, 4'h3, 16'h1234, 0, 0, 4'h0, 16'h0);
      req(0, 0, 4'h0, 16'h0, 1, 0, 4'h3, 16'h0);
      req(1, 1, 4'h5, 16'h1111, 1, 1, 4'h5, 16'h2222);
      req(1, 0, 4'h5, 16'h0, 1, 0, 4'h5, 16'h0);
      req(1, 1, 4'h7, 16'hBEEF, 1, 0, 4'h7, 16'h0);
      req(0, 0, 4'h0, 16'h0, 1, 0, 4'h7, 16'h0);
      req(1, 0, 4'h8, 16'h0, 1, 1, 4'h8, 16'h5A5A);
      req(1, 0, 4'h8, 16'h0, 0, 0, 4'h0, 16'h0);
      for (int i = 0; i < 16; i++) req(1, 1, 4'(i), 16'h0100 + 16'(i), 1, 0, 4'((i + 1) % 16), 16'h0);
      idle(3);
      check_cnt("collide_cnt");
      clear_req = 1'b1;
      req(1, 0, 4'h3, 16'h0, 1, 1, 4'h4, 16'h7777);
      clear_req = 1'b0;
      for (int i = 0; i < 16; i++) req(1, 0, 4'h3, 16'h0, 1, 1, 4'h4, 16'h7777);
      for (int i = 0; i < 16; i++) req(1, 0, 4'(i), 16'h0, 1, 0, 4'(i), 16'h0);
      idle(3);
      check_cnt("cnt_after_clear");
      clear_req = 1'b1;
      req(1, 1, 4'h2, 16'h4242, 1, 0, 4'h2, 16'h0);
      idle(0);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("pending_reset");
      step();
      rst_n = 1'b1;
      idle(5);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("sweep_reset");
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) req(1, 0, 4'h0, 16'h0, 1, 1, 4'h1, 16'h9999);
      req(1, 0, 4'h2, 16'h0, 1, 0, 4'h1, 16'h0);
      req(1, 0, 4'h9, 16'h0, 1, 0, 4'hF, 16'h0);
      idle(4);
      check_cnt("cnt_after_reset");
      for (int p = 0; p < 4; p++) chk("drain", p, 64'(qsize(p)), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
